// File: rtl/serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_adder: one full-adder cell applied LSB-first, one bit per clock.  |
// | Optional signed-overflow output: define SERIAL_ADDER_OVF_EN.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic [WIDTH-1:0] out,
  output logic             carryOut,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               carry_out_q, carry_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fa_sum;
  logic fa_carry;

  assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    cnt_d       = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d       = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d         = inA;
          b_d         = inB;
          sum_d       = '0;
          carry_d     = 1'b0;
          carry_out_d = 1'b0;
          cnt_d       = '0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d       = 1'b0;
`endif
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        if (cnt_q == LAST_BIT) begin
          // Counter parks at the last index; it is reloaded on the next start.
          carry_out_d = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d       = carry_q ^ fa_carry;
`endif
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      cnt_q       <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      cnt_q       <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out      = sum_q;
  assign carryOut = carry_out_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
`ifdef SERIAL_ADDER_OVF_EN
  assign overflow = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_adder: directed vector table plus multi-cycle corner sequences.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_serial_adder;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic [WIDTH-1:0] out;
  logic             carryOut;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             overflow;
`endif

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .inA      (inA),
    .inB      (inB),
    .out      (out),
    .carryOut (carryOut),
    .busy     (busy),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow (overflow),
`endif
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  vec_t vecs [8];

  int n_vec;
  int n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    start = 1'b1;
    inA   = a;
    inB   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    inA   = '0;
    inB   = '0;
  endtask

  // Returns the number of edges after the call until done is seen, and how
  // many of those cycles had busy low before done.
  task automatic wait_done(output int n, output int busy_low);
    n        = 0;
    busy_low = 0;
    while (!done && n < 40) begin
      if (!busy) busy_low++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n;
  int bl;
  int done_seen;

  initial begin
    n_vec = 0;
    n_bad = 0;
    start = 1'b0;
    inA   = '0;
    inB   = '0;
    reset = 1'b1;

    vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};
    vecs[6] = '{16'hAAAA, 16'h5555, 16'hFFFF, 1'b0, 1'b0};
    vecs[7] = '{16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_out",  64'(out), 64'h0);
    check("reset_cout", 64'(carryOut), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
`ifdef SERIAL_ADDER_OVF_EN
    check("reset_ovf",  64'(overflow), 64'h0);
`endif

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_after_start", i), 64'(busy), 64'h1);
      wait_done(n, bl);
      check($sformatf("v%0d_latency", i), 64'(n), 64'(WIDTH));
      check($sformatf("v%0d_busy_gap", i), 64'(bl), 64'h0);
      check($sformatf("v%0d_out", i), 64'(out), 64'(vecs[i].sum));
      check($sformatf("v%0d_cout", i), 64'(carryOut), 64'(vecs[i].cout));
      check($sformatf("v%0d_busy_in_done", i), 64'(busy), 64'h1);
`ifdef SERIAL_ADDER_OVF_EN
      check($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
`endif
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 64'(done), 64'h0);
      check($sformatf("v%0d_busy_fall", i), 64'(busy), 64'h0);
      check($sformatf("v%0d_out_hold", i), 64'(out), 64'(vecs[i].sum));
    end

    // A start during RUN and during DONE is dropped; the first legal one is at E18.
    start_op(16'h0003, 16'h0004);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    inA   = 16'h00FF;
    inB   = 16'h00FF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, bl);
    check("ign_latency", 64'(n), 64'(WIDTH - 5));
    check("ign_out", 64'(out), 64'h0007);
    check("ign_cout", 64'(carryOut), 64'h0);
    start = 1'b1;
    inA   = 16'h00FF;
    inB   = 16'h00FF;
    @(posedge clk);
    #1;
    check("ign_done_start_busy", 64'(busy), 64'h0);
    check("ign_done_start_out", 64'(out), 64'h0007);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("e18_start_busy", 64'(busy), 64'h1);
    check("e18_start_cleared_out", 64'(out), 64'h0);
    wait_done(n, bl);
    check("e18_latency", 64'(n), 64'(WIDTH));
    check("e18_out", 64'(out), 64'h01FE);
    @(posedge clk);
    #1;

    // Reset at E8 aborts, then no done pulse appears.
    start_op(16'h1111, 16'h2222);
    repeat (7) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_out", 64'(out), 64'h0);
    check("abort_cout", 64'(carryOut), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);
    check("abort_done", 64'(done), 64'h0);
`ifdef SERIAL_ADDER_OVF_EN
    check("abort_ovf", 64'(overflow), 64'h0);
`endif
    done_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done || busy) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'h0);
    start_op(16'h0001, 16'h0001);
    wait_done(n, bl);
    check("after_abort_latency", 64'(n), 64'(WIDTH));
    check("after_abort_out", 64'(out), 64'h0002);
    @(posedge clk);
    #1;

    // Reset and start together: reset wins.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    inA   = 16'h0005;
    inB   = 16'h0006;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 64'(busy), 64'h0);
    check("rst_start_out", 64'(out), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Bit-serial two's-complement adder that sits directly downstream of the `Xor` gate in the ALU datapath. It is built around a single full-adder cell, with sum = inA ^ inB ^ carry, and uses it once per clock. It takes two WIDTH-bit operands on a start strobe, adds one bit per cycle LSB-first, and presents the registered sum with a one-cycle done pulse. It is the area-cheap alternative to the ripple `Add16` for slow-path arithmetic.

## Interface
- `WIDTH`, 16: operand and sum width in bits. Legal range is 2..64.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high. Takes effect at the rising edge of `clk`.
- `start`  in  1: operand-valid strobe. Sampled only in IDLE.
- `inA`  in  WIDTH: operand A. Captured at the start edge.
- `inB`  in  WIDTH: operand B. Captured at the start edge.
- `out`  out  WIDTH: sum. Registered, holds until the next accepted start.
- `carryOut`  out  1: carry out of the MSB. Holds with `out`.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse; `out` and `carryOut` are valid while it is high.
- `overflow`  out  1: signed overflow. Present only with `SERIAL_ADDER_OVF_EN`; see Configuration.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE, with `start`=1:
  - Load shift registers a←`inA`, b←`inB`.
  - Clear carry; bit counter←0; clear `out` and `carryOut`.
  - Next state RUN.
- IDLE, with `start`=0: stay in IDLE.
- RUN, one edge per bit:
  - s = a[0]^b[0]^c, where c is the current carry.
  - c ← (a[0]&b[0]) | (c&(a[0]^b[0])).
  - a and b shift right by one.
  - `out` shifts right with s entering at bit WIDTH-1.
  - Counter increments.
- RUN exit: at the edge where the counter equals WIDTH-1, the last bit is processed. Next state DONE; `carryOut` ← final c.
- DONE: `done`=1 for exactly one cycle. Next edge goes to IDLE unconditionally.
- `start` in RUN or DONE is ignored. It is not queued.
- Counter width is clog2(WIDTH). No wrap-around beyond WIDTH-1.
- Arithmetic is modulo 2^WIDTH; the carry beyond the MSB appears only on `carryOut`.
- Reset mid-operation aborts the addition:
  - State returns to IDLE.
  - All outputs and internal registers clear to 0.
  - There is no `done` pulse.
- If `reset` and `start` are high on the same edge, reset wins.

## Timing
- Reset values: `out`=0, `carryOut`=0, `busy`=0, `done`=0, `overflow`=0.
- Start accepted at edge E0:
  - `busy` rises after E0.
  - Bits are processed at edges E1..E_WIDTH.
  - `done`=1 in the cycle after E_WIDTH.
  - `busy` and `done` fall after E_(WIDTH+1).
- Latency from start to the `done` cycle is WIDTH+1 edges (17 for WIDTH=16).
- Throughput: one addition per WIDTH+2 cycles. The earliest next start is accepted at E_(WIDTH+2).
- `out` is partial and undefined for the consumer while `busy`=1 and `done`=0.
- The inputs are don't-care except at the start edge in IDLE.

## Configuration
- Macro: `SERIAL_ADDER_OVF_EN`.
- Defined:
  - The `overflow` port exists.
  - At the final RUN edge it is set to (carry into MSB) ^ (carry out of MSB).
  - It holds with `out` and clears at reset and at an accepted start.
- Undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then `start` with inA=0x0000, inB=0x0000 → `done` at E17 with out=0x0000, carryOut=0, `busy` high from E1 to E17.
- inA=0x1234, inB=0x4321 → out=0x5555, carryOut=0, `done` high for exactly one cycle.
- inA=0xFFFF, inB=0x0001 → out=0x0000, carryOut=1; overflow=0 when the macro is defined.
- inA=0x7FFF, inB=0x0001 with `SERIAL_ADDER_OVF_EN` defined → out=0x8000, carryOut=0, overflow=1.
- `start` with 0x0003+0x0004, then `start` again with 0x00FF+0x00FF at E5 → second start ignored; out=0x0007; next start accepted only at E18 or later.
- `start`, then `reset` asserted at E8 → all outputs 0 next cycle, no `done` pulse; a fresh start of 0x0001+0x0001 gives out=0x0002.
